wb_timer: RTL and testbench



---
 rtl/wb_timer_pkg.sv | 17 +
 rtl/wb_timer_prescaler.sv | 20 ++
 rtl/wb_timer.sv | 102 ++++++++++
 tb/tb_wb_timer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_timer_pkg.sv
// wb_timer_pkg: register map, CTRL field layout and byte-lane merge helper
package wb_timer_pkg;
  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_COUNT   = 2'd1;
  localparam logic [1:0] ADDR_COMPARE = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_IE      = 1;
  localparam int CTRL_AR      = 2;
  localparam int PRESCALE_LSB = 8;
  localparam int PRESCALE_W   = 8;
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/wb_timer_prescaler.sv
// wb_timer_prescaler: divides the clock by PRESCALE+1 while enabled
module wb_timer_prescaler
  import wb_timer_pkg::*;
(
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  restart_i,
  output logic                  tick_o
);
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  assign tick_o = en_i & (cnt_q == prescale_i);
  // count 0..PRESCALE, parked at 0 when disabled or when PRESCALE is rewritten
  always_comb cnt_d = (restart_i | ~en_i | tick_o) ? '0 : cnt_q + PRESCALE_W'(1);
  // prescaler state
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/wb_timer.sv
// wb_timer: Wishbone classic timer/compare unit with W1C pending flag and irq
module wb_timer
  import wb_timer_pkg::*;
#(
  parameter int                    CNT_WIDTH    = 32,
  parameter logic [PRESCALE_W-1:0] PRESCALE_RST = '0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic        irq_o
);
  logic ack_q, err_q, irq_q, pend_q, pend_d;
  logic en_q, en_d, ie_q, ie_d, ar_q, ar_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [CNT_WIDTH-1:0] count_q, count_d, compare_q, compare_d;
  logic [31:0] dat_q, dat_d, ctrl_r, rdata, wdata;
  logic req, aligned, wr, tick, match, restart, wr_ctrl, wr_count, wr_cmp, w1c;
  logic [1:0] word;
  logic unused;
  assign unused = ^{wb_cti_i, wb_bte_i};
  assign req      = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
  assign aligned  = wb_adr_i[1:0] == 2'b00;
  assign word     = wb_adr_i[3:2];
  assign wr       = req & aligned & wb_we_i;
  assign wr_ctrl  = wr & (word == ADDR_CTRL);
  assign wr_count = wr & (word == ADDR_COUNT);
  assign wr_cmp   = wr & (word == ADDR_COMPARE);
  assign w1c      = wr & (word == ADDR_STATUS) & wb_sel_i[0] & wb_dat_i[0];
  assign restart  = wr_ctrl & wb_sel_i[PRESCALE_LSB/8];
  assign ctrl_r   = {16'h0, prescale_q, 5'h0, ar_q, ie_q, en_q};
  assign rdata    = word == ADDR_CTRL    ? ctrl_r :
                    word == ADDR_COUNT   ? 32'(count_q) :
                    word == ADDR_COMPARE ? 32'(compare_q) : {31'h0, pend_q};
  assign wdata    = byte_merge(rdata, wb_dat_i, wb_sel_i);
  // a bus write to COUNT overrides the tick, so no match is evaluated that cycle
  assign match    = tick & (count_q == compare_q) & ~wr_count;
  wb_timer_prescaler u_prescaler (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .en_i      (en_q),
    .prescale_i(prescale_q),
    .restart_i (restart),
    .tick_o    (tick)
  );
  // next-state for registers, counter and read data; a match set beats a same-cycle W1C
  always_comb begin
    en_d       = wr_ctrl ? wdata[CTRL_EN] : en_q;
    ie_d       = wr_ctrl ? wdata[CTRL_IE] : ie_q;
    ar_d       = wr_ctrl ? wdata[CTRL_AR] : ar_q;
    prescale_d = wr_ctrl ? wdata[PRESCALE_LSB +: PRESCALE_W] : prescale_q;
    count_d    = wr_count ? wdata[CNT_WIDTH-1:0] :
                 (match & ar_q) ? '0 :
                 tick ? count_q + CNT_WIDTH'(1) : count_q;
    compare_d  = wr_cmp ? wdata[CNT_WIDTH-1:0] : compare_q;
    pend_d     = match | (pend_q & ~w1c);
    dat_d      = (req & aligned & ~wb_we_i) ? rdata : '0;
  end
  // state and registered bus/irq outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
      irq_q      <= 1'b0;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      ar_q       <= 1'b0;
      prescale_q <= PRESCALE_RST;
      count_q    <= '0;
      compare_q  <= '1;
      pend_q     <= 1'b0;
    end else begin
      ack_q      <= req & aligned;
      err_q      <= req & ~aligned;
      dat_q      <= dat_d;
      irq_q      <= pend_q & ie_q;
      en_q       <= en_d;
      ie_q       <= ie_d;
      ar_q       <= ar_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      pend_q     <= pend_d;
    end
  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;
  assign irq_o    = irq_q;
endmodule

// File: tb/tb_wb_timer.sv
// tb_wb_timer: directed self-checking bench for wb_timer
module tb_wb_timer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] adr = '0, sel = '0;
  logic [31:0] dat = '0;
  logic we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic [31:0] dat_o;
  logic ack_o, err_o, rty_o, irq_o;
  int checks = 0, errors = 0, cycle = 0;
  wb_timer dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wb_adr_i (adr),
    .wb_dat_i (dat),
    .wb_sel_i (sel),
    .wb_we_i  (we),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_cti_i (3'b000),
    .wb_bte_i (2'b00),
    .wb_dat_o (dat_o),
    .wb_ack_o (ack_o),
    .wb_err_o (err_o),
    .wb_rty_o (rty_o),
    .irq_o    (irq_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;
  task automatic xfer(input logic [3:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic ak, output logic er);
    adr = a; we = w; dat = d; sel = s; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    rd = dat_o; ak = ack_o; er = err_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic ak, er;
    xfer(a, 1'b1, d, 4'hF, rd, ak, er);
  endtask
  task automatic rd_reg(input logic [3:0] a, output logic [31:0] v);
    logic ak, er;
    xfer(a, 1'b0, '0, 4'hF, v, ak, er);
  endtask
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_irq(output int t, output logic ok);
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (irq_o) begin
        ok = 1'b1;
        t = cycle;
        break;
      end
    end
  endtask
  task automatic apply_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    wait_cycles(1);
  endtask
  task automatic test_reset();
    logic [31:0] v;
    logic ok;
    int t;
    checks += 4;
    if (ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack_o); end
    if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
    if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq_o); end
    if (dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got %h want 0", dat_o); end
    wr(4'h8, 32'h37);
    wr(4'h4, 32'h37);
    wr(4'h0, 32'h3);
    wait_irq(t, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL reset_irq_setup got timeout want irq 1"); end
    adr = 4'h4; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ack_o !== 1'b1) begin errors++; $display("FAIL reset_pre_ack got %b want 1", ack_o); end
    #1 rst_n = 1'b0;
    #1;
    checks += 3;
    if (ack_o !== 1'b0) begin errors++; $display("FAIL async_ack got %b want 0", ack_o); end
    if (irq_o !== 1'b0) begin errors++; $display("FAIL async_irq got %b want 0", irq_o); end
    if (dat_o !== 32'h0) begin errors++; $display("FAIL async_dat got %h want 0", dat_o); end
    cyc = 1'b0; stb = 1'b0;
    #1 rst_n = 1'b1;
    wait_cycles(1);
    rd_reg(4'h4, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_count got %h want 0", v); end
    rd_reg(4'h0, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", v); end
    rd_reg(4'h8, v);
    checks++;
    if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_compare got %h want ffffffff", v); end
    rd_reg(4'hC, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", v); end
  endtask
  task automatic test_periodic();
    int t0, t1, t2;
    logic ok;
    apply_reset();
    wr(4'h8, 32'd5);
    t0 = cycle;
    wr(4'h0, 32'h7);
    wait_irq(t1, ok);
    checks++;
    if (!ok || t1 - t0 != 8) begin errors++; $display("FAIL periodic_first got ok=%b dt=%0d want dt=8", ok, t1 - t0); end
    wr(4'hC, 32'h1);
    checks++;
    if (irq_o !== 1'b0) begin errors++; $display("FAIL periodic_w1c_irq got %b want 0", irq_o); end
    wait_irq(t2, ok);
    checks++;
    if (!ok || t2 - t1 != 6) begin errors++; $display("FAIL periodic_period got ok=%b dt=%0d want 6", ok, t2 - t1); end
  endtask
  task automatic test_prescale();
    int t0, t1, t2;
    logic ok;
    logic [31:0] v;
    logic [31:0] exp_cnt [4] = '{32'd0, 32'd1, 32'd2, 32'd0};
    apply_reset();
    wr(4'h8, 32'd2);
    t0 = cycle;
    wr(4'h0, 32'h307);
    wait_irq(t1, ok);
    checks++;
    if (!ok || t1 - t0 != 14) begin errors++; $display("FAIL prescale_first got ok=%b dt=%0d want 14", ok, t1 - t0); end
    wr(4'hC, 32'h1);
    wait_irq(t2, ok);
    checks++;
    if (!ok || t2 - t1 != 12) begin errors++; $display("FAIL prescale_period got ok=%b dt=%0d want 12", ok, t2 - t1); end
    wait_cycles(1);
    for (int i = 0; i < 4; i++) begin
      rd_reg(4'h4, v);
      checks++;
      if (v !== exp_cnt[i]) begin errors++; $display("FAIL prescale_count%0d got %h want %h", i, v, exp_cnt[i]); end
      wait_cycles(2);
    end
  endtask
  task automatic test_handshake();
    logic [31:0] v, rd;
    logic ak, er;
    apply_reset();
    wr(4'h8, 32'h1234_5678);
    adr = 4'h8; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks += 2;
      if (ack_o !== 1'(i % 2)) begin errors++; $display("FAIL held_ack%0d got %b want %0d", i, ack_o, i % 2); end
      if (dat_o !== ((i % 2) ? 32'h1234_5678 : 32'h0)) begin errors++; $display("FAIL held_dat%0d got %h", i, dat_o); end
    end
    cyc = 1'b0; stb = 1'b0;
    wait_cycles(2);
    wr(4'h4, 32'h11);
    xfer(4'h4, 1'b1, 32'h0000_AB00, 4'b0010, rd, ak, er);
    checks++;
    if (ak !== 1'b1) begin errors++; $display("FAIL lane_write_ack got %b want 1", ak); end
    rd_reg(4'h4, v);
    checks++;
    if (v !== 32'h0000_AB11) begin errors++; $display("FAIL lane_write got %h want 0000ab11", v); end
  endtask
  task automatic test_errors();
    logic [31:0] rd;
    logic ak, er;
    apply_reset();
    wr(4'h4, 32'h1234);
    xfer(4'h5, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, ak, er);
    checks += 4;
    if (er !== 1'b1) begin errors++; $display("FAIL err_pulse got %b want 1", er); end
    if (ak !== 1'b0) begin errors++; $display("FAIL err_ack got %b want 0", ak); end
    if (rd !== 32'h0) begin errors++; $display("FAIL err_dat got %h want 0", rd); end
    if (err_o !== 1'b0) begin errors++; $display("FAIL err_width got %b want 0", err_o); end
    xfer(4'h4, 1'b0, '0, 4'hF, rd, ak, er);
    checks += 3;
    if (ak !== 1'b1 || er !== 1'b0) begin errors++; $display("FAIL err_next ack=%b err=%b want ack=1 err=0", ak, er); end
    if (rd !== 32'h1234) begin errors++; $display("FAIL err_unchanged got %h want 00001234", rd); end
    rd_reg(4'h0, rd);
    if (rd !== 32'h0) begin errors++; $display("FAIL err_ctrl got %h want 0", rd); end
  endtask
  task automatic test_collisions();
    logic [31:0] v;
    apply_reset();
    wr(4'h8, 32'd5);
    wr(4'h0, 32'h5);
    wait_cycles(4);
    wr(4'hC, 32'h1);
    rd_reg(4'hC, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL w1c_vs_match got %h want 1", v); end
    apply_reset();
    wr(4'h8, 32'd5);
    wr(4'h0, 32'h5);
    wait_cycles(4);
    wr(4'h4, 32'h0);
    rd_reg(4'hC, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL count_wr_vs_match_pend got %h want 0", v); end
    rd_reg(4'h4, v);
    checks++;
    if (v !== 32'd3) begin errors++; $display("FAIL count_wr_vs_match_count got %h want 3", v); end
  endtask
  initial begin
    #23 rst_n = 1'b1;
    wait_cycles(1);
    test_reset();
    test_periodic();
    test_prescale();
    test_handshake();
    test_errors();
    test_collisions();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
